// File: rtl/rv_width_downsizer.sv
// rtl/rv_width_downsizer.sv - ready/valid serializer, one DW-bit word out as DW/OW OW-bit beats
module rv_width_downsizer #(
  parameter int unsigned DW        = 32,
  parameter int unsigned OW        = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic          out_last,
  output logic          busy
);

  localparam int unsigned   RATIO = DW / OW;
  localparam int unsigned   CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST  = CW'(RATIO - 1);

  generate
    if ((OW == 0) || ((DW % OW) != 0) || ((DW / OW) < 2)) begin : g_param_check
      $fatal(1, "rv_width_downsizer: DW must be a multiple of OW with DW/OW >= 2");
    end
  endgenerate

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_BUSY  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] wbuf_q, wbuf_d;
  logic          on_last;
  logic          push;
  logic          pop;

  assign on_last   = (cnt_q == LAST);
  assign out_valid = (state_q == S_BUSY);
  assign out_last  = out_valid && on_last;
  assign busy      = out_valid;

  // out_ready -> in_ready is the only combinational path; it gives the zero-bubble handoff.
  assign in_ready  = (state_q == S_EMPTY) || (out_ready && on_last);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    out_data = '0;
    for (int i = 0; i < int'(RATIO); i++) begin
      if (cnt_q == CW'(i)) begin
        out_data = MSB_FIRST ? wbuf_q[DW-1-i*OW -: OW] : wbuf_q[i*OW +: OW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wbuf_d  = wbuf_q;
    case (state_q)
      S_EMPTY: begin
        if (push) begin
          wbuf_d  = in_data;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (pop) begin
          if (!on_last) begin
            cnt_d = cnt_q + CW'(1);
          end else if (push) begin
            wbuf_d = in_data;
            cnt_d  = '0;
          end else begin
            cnt_d   = '0;
            state_d = S_EMPTY;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      cnt_q   <= '0;
      wbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wbuf_q  <= wbuf_d;
    end
  end

endmodule

// File: tb/tb_rv_width_downsizer.sv
// tb/tb_rv_width_downsizer.sv - scoreboard bench for LSB-first and MSB-first downsizers
module tb_rv_width_downsizer;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        l_in_ready, l_out_valid, l_out_last, l_busy;
  logic [7:0]  l_out_data;
  logic        m_in_ready, m_out_valid, m_out_last, m_busy;
  logic [7:0]  m_out_data;

  beat_t q_l[$];
  beat_t q_m[$];
  beat_t el, em;
  int    total = 0;
  int    bad   = 0;

  rv_width_downsizer #(.DW(32), .OW(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(l_in_ready), .in_data(in_data),
    .out_valid(l_out_valid), .out_ready(out_ready), .out_data(l_out_data),
    .out_last(l_out_last), .busy(l_busy)
  );

  rv_width_downsizer #(.DW(32), .OW(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(m_in_ready), .in_data(in_data),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_data(m_out_data),
    .out_last(m_out_last), .busy(m_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_beat(input logic [31:0] w, input int i, input bit msb);
    int sh;
    sh = msb ? (24 - 8 * i) : (8 * i);
    return 8'((w >> sh) & 32'hFF);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Record expected beats for every accepted word.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (in_valid && l_in_ready)
        for (int i = 0; i < 4; i++) q_l.push_back('{data: ref_beat(in_data, i, 1'b0), last: (i == 3)});
      if (in_valid && m_in_ready)
        for (int j = 0; j < 4; j++) q_m.push_back('{data: ref_beat(in_data, j, 1'b1), last: (j == 3)});
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (l_out_valid && out_ready) begin
        if (q_l.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_l_extra: got beat %0h want none", l_out_data);
        end else begin
          el = q_l.pop_front();
          check("sb_l_data", 32'(l_out_data), 32'(el.data));
          check("sb_l_last", 32'(l_out_last), 32'(el.last));
        end
      end
      if (m_out_valid && out_ready) begin
        if (q_m.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_m_extra: got beat %0h want none", m_out_data);
        end else begin
          em = q_m.pop_front();
          check("sb_m_data", 32'(m_out_data), 32'(em.data));
          check("sb_m_last", 32'(m_out_last), 32'(em.last));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] lsb_a1 [4];
    logic [7:0] msb_a1 [4];
    logic [7:0] msb_b2b [8];
    logic       hs;
    lsb_a1  = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    msb_a1  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    msb_b2b = '{8'h03, 8'h02, 8'h01, 8'h00, 8'h07, 8'h06, 8'h05, 8'h04};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_out_valid", 32'(l_out_valid), 0);
      check("rst_out_last", 32'(l_out_last), 0);
      check("rst_out_data", 32'(l_out_data), 0);
      check("rst_in_ready", 32'(l_in_ready), 1);
      check("rst_m_out_valid", 32'(m_out_valid), 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_out_valid", 32'(l_out_valid), 0);
    check("post_rst_in_ready", 32'(l_in_ready), 1);
    check("post_rst_busy", 32'(l_busy), 0);
    step();

    // Single word, both lane orders.
    in_valid = 1'b1; in_data = 32'hA1B2C3D4; out_ready = 1'b1;
    @(negedge clk);
    check("a1_in_ready_empty", 32'(l_in_ready), 1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("a1_l_valid", 32'(l_out_valid), 1);
      check("a1_l_data", 32'(l_out_data), 32'(lsb_a1[i]));
      check("a1_l_last", 32'(l_out_last), 32'(i == 3));
      check("a1_m_data", 32'(m_out_data), 32'(msb_a1[i]));
      check("a1_m_last", 32'(m_out_last), 32'(i == 3));
      check("a1_busy", 32'(l_busy), 1);
      step();
    end
    @(negedge clk);
    check("a1_idle_valid", 32'(l_out_valid), 0);
    step();

    // Back-to-back words with zero-bubble handoff.
    in_valid = 1'b1; in_data = 32'h03020100; out_ready = 1'b1;
    step();
    in_data = 32'h07060504;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("b2b_valid", 32'(l_out_valid), 1);
      check("b2b_l_data", 32'(l_out_data), k);
      check("b2b_m_data", 32'(m_out_data), 32'(msb_b2b[k]));
      check("b2b_in_ready", 32'(l_in_ready), 32'((k == 3) || (k == 7)));
      step();
      if (k == 3) in_valid = 1'b0;
    end
    @(negedge clk);
    check("b2b_idle_valid", 32'(l_out_valid), 0);
    step();

    // Stall at beat 2, with ignored in_valid garbage while in_ready is low.
    in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("st_b0", 32'(l_out_data), 32'hEF);
    step();
    @(negedge clk);
    check("st_b1", 32'(l_out_data), 32'hBE);
    step();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h12345678;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check("st_hold_data", 32'(l_out_data), 32'hAD);
      check("st_hold_valid", 32'(l_out_valid), 1);
      check("st_hold_in_ready", 32'(l_in_ready), 0);
      check("st_hold_last", 32'(l_out_last), 0);
      check("st_hold_m_data", 32'(m_out_data), 32'hBE);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("st_resume_b2", 32'(l_out_data), 32'hAD);
    check("st_resume_in_ready", 32'(l_in_ready), 0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("st_b3_data", 32'(l_out_data), 32'hDE);
    check("st_b3_last", 32'(l_out_last), 1);
    check("st_b3_in_ready", 32'(l_in_ready), 1);
    check("st_b3_m_data", 32'(m_out_data), 32'hEF);
    step();
    @(negedge clk);
    check("st_idle_valid", 32'(l_out_valid), 0);
    step();

    // Random traffic: upstream holds each word until accepted, as a 1-deep FIFO would.
    in_valid = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      hs = in_valid && l_in_ready;
      step();
      if (!in_valid || hs) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_data  = $urandom;
      end
      out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      step();
    end
    @(negedge clk);
    check("drain_q_l_empty", 32'(q_l.size()), 0);
    check("drain_q_m_empty", 32'(q_m.size()), 0);
    check("drain_out_valid", 32'(l_out_valid), 0);
    step();

    // Reset mid-word discards the remaining beats at once.
    in_valid = 1'b1; in_data = $urandom; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(l_out_valid), 0);
    check("mid_rst_m_out_valid", 32'(m_out_valid), 0);
    check("mid_rst_in_ready", 32'(l_in_ready), 1);
    check("mid_rst_out_data", 32'(l_out_data), 0);
    q_l.delete();
    q_m.delete();
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("after_rst_out_valid", 32'(l_out_valid), 0);
    step();

    in_valid = 1'b1; in_data = 32'h0BADF00D; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      step();
    end
    @(negedge clk);
    check("recover_q_l_empty", 32'(q_l.size()), 0);
    check("recover_q_m_empty", 32'(q_m.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
